tx_arbiter_module: RTL and testbench

TX_ARBITER_MODULE -- requirements
Module: tx_arbiter_module

---
 rtl/tx_arbiter_module.sv | 159 +++++++++++++++
 tb/tb_tx_arbiter_module.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter_module.sv
// tx_arbiter_module
// Round-robin arbiter that lets four requesters share one UART transmitter.
// One byte is sent per grant. A frame ends on the transmitter's done pulse
// (the requester gets an Ack) or when a cycle budget runs out (Timeout).
//
// Ports:
//   CLK          in   1   system clock, rising edge
//   RSTn         in   1   asynchronous active-low reset
//   Req_Sig      in   4   level requests, bit i = requester i has a byte
//   Req_Data     in  32   byte of requester i on [8i+7:8i]
//   Ack_Sig      out  4   one-cycle pulse, bit i = requester i's byte sent
//   TX_Data      out  8   byte presented to the transmitter
//   TX_En_Sig    out  1   transmitter enable, high for the whole frame
//   TX_Done_Sig  in   1   one-cycle frame-complete pulse from transmitter
//   Busy_Sig     out  1   high whenever the FSM is not in IDLE
//   Grant_Idx    out  2   current or most recent granted requester
//   Timeout_Sig  out  1   one-cycle pulse when a frame is aborted
module tx_arbiter_module #(
    parameter int TIMEOUT_CYC = 60000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  Req_Sig,
    input  logic [31:0] Req_Data,
    output logic [3:0]  Ack_Sig,
    output logic [7:0]  TX_Data,
    output logic        TX_En_Sig,
    input  logic        TX_Done_Sig,
    output logic        Busy_Sig,
    output logic [1:0]  Grant_Idx,
    output logic        Timeout_Sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last SEND cycle: the counter is 0 in the first SEND cycle, so this
    // value is reached in SEND cycle number TIMEOUT_CYC.
    localparam logic [19:0] TERM_CNT = 20'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  ack_d;
    logic [7:0]  tx_data_d;
    logic        tx_en_d;
    logic        busy_d;
    logic [1:0]  grant_d;
    logic        timeout_d;

    logic        rr_found;
    logic [1:0]  rr_idx;
    logic [1:0]  rr_cand;

    // Round-robin search starting just after the last served requester and
    // wrapping back to it, so the last one served has the lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_q;
        rr_cand  = last_q;
        for (int i = 1; i <= 4; i++) begin
            rr_cand = last_q + 2'(i);
            if (!rr_found && Req_Sig[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Next-state and next-output logic. Every output is computed here one
    // cycle early and registered below, so nothing combinational leaves the
    // block. The pointer moves on both completion and timeout so a stuck
    // requester cannot hog the transmitter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tx_data_d = TX_Data;
        grant_d   = Grant_Idx;
        tx_en_d   = TX_En_Sig;
        busy_d    = Busy_Sig;
        ack_d     = 4'b0000;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                if (rr_found) begin
                    state_d   = SEND;
                    tx_data_d = Req_Data[{rr_idx, 3'b000} +: 8];
                    grant_d   = rr_idx;
                    tx_en_d   = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = 20'd0;
                end
            end
            SEND: begin
                cnt_d   = cnt_q + 20'd1;
                tx_en_d = 1'b1;
                busy_d  = 1'b1;
                // Done is tested first so it wins over a coincident timeout.
                if (TX_Done_Sig) begin
                    state_d = DONE;
                    tx_en_d = 1'b0;
                    ack_d   = 4'b0001 << Grant_Idx;
                    last_d  = Grant_Idx;
                end else if (cnt_q == TERM_CNT) begin
                    state_d   = DONE;
                    tx_en_d   = 1'b0;
                    timeout_d = 1'b1;
                    last_d    = Grant_Idx;
                end
            end
            DONE: begin
                state_d = IDLE;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 20'd0;
            end
            default: begin
                state_d = IDLE;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = 20'd0;
            end
        endcase
    end

    // State and output registers. Reset gives requester 0 first priority by
    // parking the pointer at 3.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            cnt_q       <= 20'd0;
            last_q      <= 2'd3;
            Ack_Sig     <= 4'b0000;
            TX_Data     <= 8'h00;
            TX_En_Sig   <= 1'b0;
            Busy_Sig    <= 1'b0;
            Grant_Idx   <= 2'd0;
            Timeout_Sig <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            Ack_Sig     <= ack_d;
            TX_Data     <= tx_data_d;
            TX_En_Sig   <= tx_en_d;
            Busy_Sig    <= busy_d;
            Grant_Idx   <= grant_d;
            Timeout_Sig <= timeout_d;
        end
    end

endmodule

// File: tb/tb_tx_arbiter_module.sv
// tb_tx_arbiter_module
// Directed bench for tx_arbiter_module with TIMEOUT_CYC = 16. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
module tb_tx_arbiter_module;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_sig;
    logic [31:0] req_data;
    logic        tx_done;
    logic [3:0]  ack_sig;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        busy;
    logic [1:0]  grant_idx;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    // Byte of requester i is 8'h11 * (i + 1).
    localparam logic [31:0] DATA_ALL = 32'h44332211;

    tx_arbiter_module #(
        .TIMEOUT_CYC(16)
    ) dut (
        .CLK        (clk),
        .RSTn       (rst_n),
        .Req_Sig    (req_sig),
        .Req_Data   (req_data),
        .Ack_Sig    (ack_sig),
        .TX_Data    (tx_data),
        .TX_En_Sig  (tx_en),
        .TX_Done_Sig(tx_done),
        .Busy_Sig   (busy),
        .Grant_Idx  (grant_idx),
        .Timeout_Sig(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data,
                                 input logic done);
        req_sig  = req;
        req_data = data;
        tx_done  = done;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Steps until TX_En_Sig is seen high, counting the low cycles seen on the
    // way; gives up after a fixed budget.
    task automatic waitTxEn(output int lows, output logic found);
        lows  = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_en === 1'b1) begin
                found = 1'b1;
                break;
            end
            lows++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_en"},   32'(tx_en),     32'h0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data),   32'h00);
        checkOutput({tag, "_ack"},     32'(ack_sig),   32'h0);
        checkOutput({tag, "_busy"},    32'(busy),      32'h0);
        checkOutput({tag, "_timeout"}, 32'(timeout),   32'h0);
        checkOutput({tag, "_grant"},   32'(grant_idx), 32'h0);
    endtask

    initial begin
        int   lows;
        logic found;
        int   exp_idx;

        rst_n = 1'b0;
        applyStimulus(4'b0000, 32'h0, 1'b0);
        tick();
        tick();
        checkResetValues("reset");
        rst_n = 1'b1;
        tick();

        // A done pulse outside SEND must be ignored.
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        tick();
        checkOutput("idle_done_ack", 32'(ack_sig), 32'h0);
        checkOutput("idle_done_en",  32'(tx_en),   32'h0);
        checkOutput("idle_busy",     32'(busy),    32'h0);

        // Single request from requester 1 with byte A5.
        $display("[TB] single request");
        applyStimulus(4'b0010, 32'h0000A500, 1'b0);
        tick();
        checkOutput("single_en",    32'(tx_en),     32'h1);
        checkOutput("single_data",  32'(tx_data),   32'hA5);
        checkOutput("single_grant", 32'(grant_idx), 32'h1);
        checkOutput("single_busy",  32'(busy),      32'h1);
        // Data changes while sending must not reach TX_Data; the request
        // also drops and the frame still completes.
        applyStimulus(4'b0000, 32'hFFFFFFFF, 1'b0);
        tick();
        checkOutput("single_hold_data", 32'(tx_data), 32'hA5);
        applyStimulus(4'b0000, 32'hFFFFFFFF, 1'b1);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        checkOutput("single_ack",      32'(ack_sig), 32'h2);
        checkOutput("single_en_low",   32'(tx_en),   32'h0);
        checkOutput("single_done_bsy", 32'(busy),    32'h1);
        checkOutput("single_no_to",    32'(timeout), 32'h0);
        tick();
        checkOutput("single_ack_clr", 32'(ack_sig), 32'h0);
        checkOutput("single_idle_bsy", 32'(busy),   32'h0);

        // All four requesting from reset: grants 0,1,2,3,0.
        $display("[TB] round robin");
        rst_n = 1'b0;
        applyStimulus(4'b1111, DATA_ALL, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int gap;
            waitTxEn(gap, found);
            exp_idx = k % 4;
            checkOutput("rr_en_seen", 32'(found), 32'h1);
            checkOutput("rr_grant", 32'(grant_idx), 32'(exp_idx));
            checkOutput("rr_data", 32'(tx_data), 32'(8'h11 * (exp_idx + 1)));
            if (k > 0) checkOutput("rr_gap_ge2", 32'(gap + lows >= 2), 32'h1);
            tick();
            tick();
            applyStimulus(4'b1111, DATA_ALL, 1'b1);
            tick();
            applyStimulus(4'b1111, DATA_ALL, 1'b0);
            checkOutput("rr_ack", 32'(ack_sig), 32'(4'b0001 << exp_idx));
            lows = (tx_en === 1'b0) ? 1 : 0;
        end

        // Pointer now at 0: with requests 0 and 2, requester 2 goes first.
        $display("[TB] pointer order");
        applyStimulus(4'b0000, DATA_ALL, 1'b0);
        tick();
        tick();
        applyStimulus(4'b0101, DATA_ALL, 1'b0);
        tick();
        checkOutput("ptr_grant2", 32'(grant_idx), 32'h2);
        checkOutput("ptr_data2",  32'(tx_data),   32'h33);
        applyStimulus(4'b0101, DATA_ALL, 1'b1);
        tick();
        applyStimulus(4'b0101, DATA_ALL, 1'b0);
        checkOutput("ptr_ack2", 32'(ack_sig), 32'h4);
        waitTxEn(lows, found);
        checkOutput("ptr_en_seen", 32'(found),     32'h1);
        checkOutput("ptr_grant0",  32'(grant_idx), 32'h0);
        checkOutput("ptr_data0",   32'(tx_data),   32'h11);
        applyStimulus(4'b0000, DATA_ALL, 1'b1);
        tick();
        applyStimulus(4'b0000, DATA_ALL, 1'b0);
        checkOutput("ptr_ack0", 32'(ack_sig), 32'h1);
        tick();
        tick();

        // Timeout: pointer at 0, all requesting -> requester 1, no done.
        $display("[TB] timeout");
        applyStimulus(4'b1111, DATA_ALL, 1'b0);
        tick();
        checkOutput("to_grant1", 32'(grant_idx), 32'h1);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("to_still_en",  32'(tx_en),   32'h1);
        checkOutput("to_not_early", 32'(timeout), 32'h0);
        tick();
        checkOutput("to_pulse",  32'(timeout), 32'h1);
        checkOutput("to_no_ack", 32'(ack_sig), 32'h0);
        checkOutput("to_en_low", 32'(tx_en),   32'h0);
        tick();
        checkOutput("to_pulse_end", 32'(timeout), 32'h0);
        tick();
        checkOutput("to_next_grant", 32'(grant_idx), 32'h2);
        checkOutput("to_next_en",    32'(tx_en),     32'h1);

        // Done coinciding with the terminal count: done wins.
        $display("[TB] done vs timeout");
        for (int i = 0; i < 15; i++) tick();
        applyStimulus(4'b1111, DATA_ALL, 1'b1);
        tick();
        applyStimulus(4'b1111, DATA_ALL, 1'b0);
        checkOutput("tie_ack",     32'(ack_sig), 32'h4);
        checkOutput("tie_timeout", 32'(timeout), 32'h0);
        tick();
        checkOutput("tie_timeout2", 32'(timeout), 32'h0);
        checkOutput("tie_ack_clr",  32'(ack_sig), 32'h0);

        // Reset during SEND.
        $display("[TB] reset during send");
        waitTxEn(lows, found);
        checkOutput("rst_en_seen", 32'(found),     32'h1);
        checkOutput("rst_grant3",  32'(grant_idx), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("rst_mid");
        applyStimulus(4'b1000, DATA_ALL, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_grant", 32'(grant_idx), 32'h3);
        checkOutput("post_rst_data",  32'(tx_data),   32'h44);
        checkOutput("post_rst_ack",   32'(ack_sig),   32'h0);
        checkOutput("post_rst_to",    32'(timeout),   32'h0);
        applyStimulus(4'b0000, DATA_ALL, 1'b1);
        tick();
        applyStimulus(4'b0000, DATA_ALL, 1'b0);
        checkOutput("post_rst_ack3", 32'(ack_sig), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=stalled expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
